// File: rtl/dir_input_ctrl.sv
// Per-player pad synchronizer, debouncer and direction register, plus the IDLE/RUN/FROZEN game FSM.
// Optional macro DIR_REVERSAL_BLOCK_EN rejects presses directly opposite the current direction.
module dir_input_ctrl #(
  parameter int NUM_PLAYERS = 2,
  parameter int DEB_CYCLES  = 400000
) (
  input  logic                     clk_40MHz,
  input  logic                     reset,
  input  logic                     btn_reset,
  input  logic                     collided,
  input  logic [4*NUM_PLAYERS-1:0] pad_in,
  output logic [4*NUM_PLAYERS-1:0] dir_out,
  output logic [NUM_PLAYERS-1:0]   dir_valid,
  output logic [1:0]               game_state
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    FROZEN = 2'b10
  } state_t;

  state_t r_state, w_state_nxt;

  logic [NUM_PLAYERS-1:0] w_load;
  logic                   w_allow;
  logic                   w_zero;

  // A collision edge takes priority over any accept landing in the same cycle.
  assign w_zero  = (r_state == FROZEN) || ((r_state == RUN) && collided);
  assign w_allow = !btn_reset && !w_zero;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_lane
    localparam logic [3:0] START = (p % 2 == 1) ? 4'b0010 : 4'b0001;

    logic [3:0]    r_sync1, r_sync2, r_last, r_dir;
    logic [CW-1:0] r_cnt;
    logic          r_vld;
    logic          w_acc, w_onehot, w_rev;
    logic [3:0]    w_opp;

    assign w_acc    = (r_sync2 == r_last) && (r_cnt == CW'(DEB_CYCLES - 1));
    assign w_onehot = $onehot(r_sync2);
    // Bit order {down, up, right, left}: swap within each axis pair.
    assign w_opp    = {r_dir[2], r_dir[3], r_dir[0], r_dir[1]};
`ifdef DIR_REVERSAL_BLOCK_EN
    assign w_rev    = (r_sync2 == w_opp);
`else
    assign w_rev    = 1'b0;
`endif
    assign w_load[p] = w_acc && w_onehot && (r_sync2 != r_dir) && !w_rev && w_allow;

    always_ff @(posedge clk_40MHz or posedge reset) begin
      if (reset) begin
        r_sync1 <= '0;
        r_sync2 <= '0;
        r_last  <= '0;
      end else begin
        r_sync1 <= pad_in[4*p +: 4];
        r_sync2 <= r_sync1;
        r_last  <= r_sync2;
      end
    end

    always_ff @(posedge clk_40MHz or posedge reset) begin
      if (reset) begin
        r_cnt <= '0;
      end else if (btn_reset || (r_sync2 != r_last)) begin
        r_cnt <= '0;
      end else if (r_cnt != CW'(DEB_CYCLES)) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end

    always_ff @(posedge clk_40MHz or posedge reset) begin
      if (reset) begin
        r_dir <= START;
        r_vld <= 1'b0;
      end else if (btn_reset) begin
        r_dir <= START;
        r_vld <= 1'b0;
      end else if (w_zero) begin
        r_dir <= '0;
        r_vld <= 1'b0;
      end else if (w_load[p]) begin
        r_dir <= r_sync2;
        r_vld <= 1'b1;
      end else begin
        r_vld <= 1'b0;
      end
    end

    assign dir_out[4*p +: 4] = r_dir;
    assign dir_valid[p]      = r_vld;
  end

  always_ff @(posedge clk_40MHz or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (btn_reset) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (|w_load) w_state_nxt = RUN;
        RUN:     if (collided) w_state_nxt = FROZEN;
        FROZEN:  w_state_nxt = FROZEN;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign game_state = r_state;
endmodule

// File: tb/tb_dir_input_ctrl.sv
// Directed bench for dir_input_ctrl with NUM_PLAYERS=2, DEB_CYCLES=4.
module tb_dir_input_ctrl;
  logic       clk_40MHz = 1'b0;
  logic       reset, btn_reset, collided;
  logic [7:0] pad_in, dir_out;
  logic [1:0] dir_valid, game_state;
  int         vecs = 0;
  int         errs = 0;

  always #5 clk_40MHz = ~clk_40MHz;

  dir_input_ctrl #(.NUM_PLAYERS(2), .DEB_CYCLES(4)) dut (
    .clk_40MHz (clk_40MHz),
    .reset     (reset),
    .btn_reset (btn_reset),
    .collided  (collided),
    .pad_in    (pad_in),
    .dir_out   (dir_out),
    .dir_valid (dir_valid),
    .game_state(game_state)
  );

  task automatic tick();
    @(posedge clk_40MHz);
    #1;
  endtask

  task automatic press(input logic [7:0] v, input int h, input int r);
    pad_in = v;
    repeat (h) tick();
    pad_in = 8'h00;
    repeat (r) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; btn_reset = 1'b0; collided = 1'b0; pad_in = 8'h00;
    #1 reset = 1'b1;
    #2;
    vecs++; if (game_state !== 2'b00) begin errs++; $display("FAIL reset_state got %b exp 00", game_state); end
    vecs++; if (dir_out !== 8'h21) begin errs++; $display("FAIL reset_dir got %h exp 21", dir_out); end
    vecs++; if (dir_valid !== 2'b00) begin errs++; $display("FAIL reset_valid got %b exp 00", dir_valid); end
    tick(); tick();
    reset = 1'b0;
    repeat (8) tick();
    vecs++; if (dir_out !== 8'h21) begin errs++; $display("FAIL post_reset_dir got %h exp 21", dir_out); end
  endtask

  task automatic test_accept();
    pad_in = 8'h04;
    for (int i = 1; i <= 6; i++) begin
      tick();
      vecs++; if (dir_valid !== 2'b00) begin errs++; $display("FAIL acc_early_valid cyc %0d got %b exp 00", i, dir_valid); end
    end
    vecs++; if (dir_out !== 8'h21) begin errs++; $display("FAIL acc_early_dir got %h exp 21", dir_out); end
    tick();
    vecs++; if (dir_out !== 8'h24) begin errs++; $display("FAIL acc_dir got %h exp 24", dir_out); end
    vecs++; if (dir_valid !== 2'b01) begin errs++; $display("FAIL acc_valid got %b exp 01", dir_valid); end
    vecs++; if (game_state !== 2'b01) begin errs++; $display("FAIL acc_state got %b exp 01", game_state); end
    tick();
    vecs++; if (dir_valid !== 2'b00) begin errs++; $display("FAIL acc_pulse_len got %b exp 00", dir_valid); end
    pad_in = 8'h00;
    repeat (10) tick();
    vecs++; if (dir_out !== 8'h24) begin errs++; $display("FAIL acc_release_dir got %h exp 24", dir_out); end
  endtask

  task automatic test_glitch();
    pad_in = 8'h80;
    repeat (3) tick();
    pad_in = 8'h00;
    for (int i = 0; i < 12; i++) begin
      tick();
      vecs++; if (dir_valid !== 2'b00) begin errs++; $display("FAIL glitch_valid cyc %0d got %b exp 00", i, dir_valid); end
    end
    vecs++; if (dir_out !== 8'h24) begin errs++; $display("FAIL glitch_dir got %h exp 24", dir_out); end
  endtask

  task automatic test_multibit();
    pad_in = 8'h03;
    for (int i = 0; i < 10; i++) begin
      tick();
      vecs++; if (dir_valid !== 2'b00) begin errs++; $display("FAIL multi_valid cyc %0d got %b exp 00", i, dir_valid); end
    end
    pad_in = 8'h00;
    repeat (10) tick();
    vecs++; if (dir_out !== 8'h24) begin errs++; $display("FAIL multi_dir got %h exp 24", dir_out); end
    vecs++; if (game_state !== 2'b01) begin errs++; $display("FAIL multi_state got %b exp 01", game_state); end
  endtask

  task automatic test_back_to_back();
    pad_in = 8'h41;
    repeat (6) tick();
    tick();
    vecs++; if (dir_out !== 8'h41) begin errs++; $display("FAIL simul_dir got %h exp 41", dir_out); end
    vecs++; if (dir_valid !== 2'b11) begin errs++; $display("FAIL simul_valid got %b exp 11", dir_valid); end
    tick();
    pad_in = 8'h00;
    repeat (10) tick();
    pad_in = 8'h41;
    for (int i = 0; i < 10; i++) begin
      tick();
      vecs++; if (dir_valid !== 2'b00) begin errs++; $display("FAIL same_valid cyc %0d got %b exp 00", i, dir_valid); end
    end
    pad_in = 8'h00;
    repeat (10) tick();
    vecs++; if (dir_out !== 8'h41) begin errs++; $display("FAIL same_dir got %h exp 41", dir_out); end
  endtask

  task automatic test_reversal();
    logic [7:0] exp_dir;
    logic [1:0] exp_vld;
    press(8'h04, 8, 10);
    press(8'h02, 8, 10);
    vecs++; if (dir_out !== 8'h42) begin errs++; $display("FAIL rev_setup_dir got %h exp 42", dir_out); end
`ifdef DIR_REVERSAL_BLOCK_EN
    exp_dir = 8'h42; exp_vld = 2'b00;
`else
    exp_dir = 8'h41; exp_vld = 2'b01;
`endif
    pad_in = 8'h01;
    repeat (7) tick();
    vecs++; if (dir_out !== exp_dir) begin errs++; $display("FAIL rev_dir got %h exp %h", dir_out, exp_dir); end
    vecs++; if (dir_valid !== exp_vld) begin errs++; $display("FAIL rev_valid got %b exp %b", dir_valid, exp_vld); end
    tick();
    pad_in = 8'h00;
    repeat (10) tick();
  endtask

  task automatic test_freeze();
    vecs++; if (game_state !== 2'b01) begin errs++; $display("FAIL frz_pre_state got %b exp 01", game_state); end
    collided = 1'b1;
    tick();
    collided = 1'b0;
    vecs++; if (game_state !== 2'b10) begin errs++; $display("FAIL frz_state got %b exp 10", game_state); end
    vecs++; if (dir_out !== 8'h00) begin errs++; $display("FAIL frz_dir got %h exp 00", dir_out); end
    pad_in = 8'h84;
    for (int i = 0; i < 10; i++) begin
      tick();
      vecs++; if (dir_valid !== 2'b00) begin errs++; $display("FAIL frz_valid cyc %0d got %b exp 00", i, dir_valid); end
    end
    vecs++; if (dir_out !== 8'h00) begin errs++; $display("FAIL frz_hold_dir got %h exp 00", dir_out); end
    vecs++; if (game_state !== 2'b10) begin errs++; $display("FAIL frz_hold_state got %b exp 10", game_state); end
    pad_in = 8'h00;
    btn_reset = 1'b1;
    tick();
    btn_reset = 1'b0;
    vecs++; if (game_state !== 2'b00) begin errs++; $display("FAIL btn_state got %b exp 00", game_state); end
    vecs++; if (dir_out !== 8'h21) begin errs++; $display("FAIL btn_dir got %h exp 21", dir_out); end
    vecs++; if (dir_valid !== 2'b00) begin errs++; $display("FAIL btn_valid got %b exp 00", dir_valid); end
    repeat (4) tick();
    collided = 1'b1;
    tick();
    collided = 1'b0;
    vecs++; if (game_state !== 2'b00) begin errs++; $display("FAIL idle_collide_state got %b exp 00", game_state); end
    repeat (8) tick();
  endtask

  task automatic test_btn_collide();
    press(8'h04, 8, 10);
    vecs++; if (game_state !== 2'b01) begin errs++; $display("FAIL bc_pre_state got %b exp 01", game_state); end
    vecs++; if (dir_out !== 8'h24) begin errs++; $display("FAIL bc_pre_dir got %h exp 24", dir_out); end
    btn_reset = 1'b1; collided = 1'b1;
    tick();
    btn_reset = 1'b0; collided = 1'b0;
    vecs++; if (game_state !== 2'b00) begin errs++; $display("FAIL bc_state got %b exp 00", game_state); end
    vecs++; if (dir_out !== 8'h21) begin errs++; $display("FAIL bc_dir got %h exp 21", dir_out); end
    vecs++; if (dir_valid !== 2'b00) begin errs++; $display("FAIL bc_valid got %b exp 00", dir_valid); end
    repeat (4) tick();
  endtask

  task automatic test_midreset();
    press(8'h04, 8, 10);
    vecs++; if (game_state !== 2'b01) begin errs++; $display("FAIL mr_pre_state got %b exp 01", game_state); end
    pad_in = 8'h02;
    repeat (4) tick();
    reset = 1'b1;
    #1;
    vecs++; if (game_state !== 2'b00) begin errs++; $display("FAIL mr_state got %b exp 00", game_state); end
    vecs++; if (dir_out !== 8'h21) begin errs++; $display("FAIL mr_dir got %h exp 21", dir_out); end
    tick(); tick();
    pad_in = 8'h00;
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      vecs++; if (dir_valid !== 2'b00) begin errs++; $display("FAIL mr_valid cyc %0d got %b exp 00", i, dir_valid); end
    end
    vecs++; if (dir_out !== 8'h21) begin errs++; $display("FAIL mr_final_dir got %h exp 21", dir_out); end
    vecs++; if (game_state !== 2'b00) begin errs++; $display("FAIL mr_final_state got %b exp 00", game_state); end
  endtask

  initial begin
    test_reset();
    test_accept();
    test_glitch();
    test_multibit();
    test_back_to_back();
    test_reversal();
    test_freeze();
    test_btn_collide();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/dir_input_ctrl.md
DIR_INPUT_CTRL -- requirements
Module: dir_input_ctrl

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2, number of independent direction input channels (legal 1..8).
REQ-002 SHALL have parameter DEB_CYCLES, default 400000, number of consecutive stable cycles required to accept a pad vector (10 ms at 40 MHz; legal >= 1).
REQ-003 SHALL have port clk_40MHz  input  1  pixel/system clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high.
REQ-005 SHALL have port btn_reset  input  1  synchronous game restart, already synchronized to clk_40MHz.
REQ-006 SHALL have port collided  input  1  synchronous collision flag from trace logic.
REQ-007 SHALL have port pad_in  input  4*NUM_PLAYERS  raw asynchronous pads; per player p, bits [4p+3:4p] = {down, up, right, left}.
REQ-008 SHALL have port dir_out  output  4*NUM_PLAYERS  current one-hot direction per player, same bit order as pad_in; all-zero means stopped.
REQ-009 SHALL have port dir_valid  output  NUM_PLAYERS  one-cycle pulse when that player's dir_out changes due to an accepted press.
REQ-010 SHALL have port game_state  output  2  00 IDLE, 01 RUN, 10 FROZEN.

Function
REQ-011 SHALL pass each pad_in bit through a two-flop synchronizer before any other use.
REQ-012 SHALL keep, per player, a last-sample register and a stable counter wide enough for DEB_CYCLES (saturating, no wrap).
REQ-013 SHALL clear the counter when the synchronized vector differs from last-sample, and increment it otherwise until it saturates at DEB_CYCLES.
REQ-014 SHALL raise one accept event for a player in the cycle its counter goes from DEB_CYCLES-1 to DEB_CYCLES; at most one accept per stable episode.
REQ-015 SHALL discard an accepted vector that is not exactly one-hot (all-zero release or multiple bits set); dir_out holds.
REQ-016 SHALL discard an accepted vector equal to the current dir_out, with no dir_valid pulse.
REQ-017 SHALL load an accepted one-hot vector into dir_out on the next edge and pulse dir_valid for that player in the same cycle, only in IDLE or RUN.
REQ-018 SHALL give dir_out a start value of 4'b0001 (left) for even player indices and 4'b0010 (right) for odd player indices.
REQ-019 SHALL implement FSM IDLE -> RUN on the first loaded direction from any player.
REQ-020 SHALL implement FSM RUN -> FROZEN when collided=1; collided is ignored in IDLE and FROZEN.
REQ-021 SHALL force all dir_out to zero on entry to FROZEN, hold them at zero, and ignore all accepts while FROZEN.
REQ-022 SHALL, on btn_reset=1 in any state, go to IDLE, load the start directions, clear debounce counters and emit no dir_valid.
REQ-023 SHALL give btn_reset priority when btn_reset and collided are both 1 in the same cycle.
REQ-024 SHALL process players independently; simultaneous accepts from several players all load in the same cycle.
REQ-025 SHALL update dir_out DEB_CYCLES+2 edges after a new pad value is first sampled by the synchronizer, provided the value stays constant.

Reset
REQ-026 SHALL, on reset assertion, immediately set game_state=IDLE, dir_out=start values, dir_valid=0, counters=0, last-sample=0 and synchronizers=0.
REQ-027 SHALL abort any debounce in progress on reset mid-operation; no accept fires from pre-reset samples.

Configuration
REQ-028 SHALL, with macro DIR_REVERSAL_BLOCK_EN defined, discard an accepted press that is directly opposite the current dir_out (left<->right, up<->down), with no dir_valid pulse.
REQ-029 SHALL, without DIR_REVERSAL_BLOCK_EN, load opposite-direction presses like any other one-hot press.

Verification (NUM_PLAYERS=2, DEB_CYCLES=4)
REQ-030 SHALL cover: reset, then P0 pad 4'b0100 held 8 cycles -> dir_out[3:0]=0100 exactly 6 edges after first sample, dir_valid[0] for 1 cycle, game_state=01.
REQ-031 SHALL cover: P1 pad 4'b1000 held 3 cycles then 0 -> no change to dir_out[7:4]=0010, no dir_valid.
REQ-032 SHALL cover: in RUN, P0 pad 4'b0011 held 10 cycles -> dir_out unchanged, no dir_valid.
REQ-033 SHALL cover: in RUN, collided=1 for 1 cycle -> game_state=10, dir_out=0; later presses ignored; btn_reset=1 -> game_state=00, dir_out={0010,0001}.
REQ-034 SHALL cover: P0 dir=0010, P0 pad 4'b0001 held 8 cycles -> with DIR_REVERSAL_BLOCK_EN dir_out[3:0] stays 0010; without it dir_out[3:0]=0001.
REQ-035 SHALL cover: btn_reset and collided asserted in the same RUN cycle -> game_state=00 and start directions loaded.
